// File: rtl/tti_rx_packer.sv
// rtl/tti_rx_packer.sv - packs received I3C private-write bytes into 32-bit RX data words plus one descriptor per transfer
// Optional error-flag feature (byte_err_i, descriptor bit 17) enabled by I3C_TTI_RX_ERR_FLAG_EN.
module tti_rx_packer #(
  parameter int RxDataWidth     = 32,
  parameter int RxDescDataWidth = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       xfer_start_i,
  input  logic                       xfer_end_i,
  input  logic                       byte_valid_i,
  input  logic [7:0]                 byte_i,
`ifdef I3C_TTI_RX_ERR_FLAG_EN
  input  logic                       byte_err_i,
`endif
  output logic                       rx_data_queue_wvalid_o,
  input  logic                       rx_data_queue_wready_i,
  output logic [RxDataWidth-1:0]     rx_data_queue_wdata_o,
  output logic                       rx_desc_queue_wvalid_o,
  input  logic                       rx_desc_queue_wready_i,
  output logic [RxDescDataWidth-1:0] rx_desc_queue_wdata_o,
  output logic                       busy_o,
  output logic                       byte_dropped_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_FLUSH,
    ST_DESC
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_acc;
  logic [2:0]  r_acc_cnt;
  logic [31:0] r_pend;
  logic        r_pend_v;
  logic [15:0] r_byte_cnt;
  logic        r_ovf;
  logic        r_err;
  logic        r_dropped;

  logic        w_data_hs;
  logic        w_desc_hs;
  logic        w_acc_full;
  logic        w_acc_move;
  logic        w_accept;
  logic        w_drop;
  logic [31:0] w_acc_nxt;
  logic [2:0]  w_cnt_base;
  logic [2:0]  w_acc_cnt_nxt;
  logic        w_err;

  assign w_data_hs  = r_pend_v && rx_data_queue_wready_i;
  assign w_desc_hs  = (r_state == ST_DESC) && rx_desc_queue_wready_i;
  assign w_acc_full = (r_acc_cnt == 3'd4);

  // A full word (or, while flushing, any residue) moves to pending once pending frees up.
  assign w_acc_move = (r_acc_cnt != 3'd0) &&
                      (w_acc_full || (r_state == ST_FLUSH)) &&
                      (!r_pend_v || w_data_hs);

  assign w_accept = byte_valid_i && (r_state == ST_RECV) && (!w_acc_full || w_acc_move);
  assign w_drop   = byte_valid_i && !w_accept;

`ifdef I3C_TTI_RX_ERR_FLAG_EN
  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_acc_nxt     = w_acc_move ? 32'd0 : r_acc;
    w_cnt_base    = w_acc_move ? 3'd0 : r_acc_cnt;
    w_acc_cnt_nxt = w_cnt_base;
    if (w_accept) begin
      w_acc_nxt[{w_cnt_base[1:0], 3'b000} +: 8] = byte_i;
      w_acc_cnt_nxt                             = w_cnt_base + 3'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (xfer_start_i) w_state_nxt = ST_RECV;
      ST_RECV:  if (xfer_end_i) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if ((r_acc_cnt == 3'd0) && !r_pend_v) w_state_nxt = ST_DESC;
      ST_DESC:  if (rx_desc_queue_wready_i) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc     <= 32'd0;
      r_acc_cnt <= 3'd0;
      r_pend    <= 32'd0;
      r_pend_v  <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_acc     <= w_acc_nxt;
      r_acc_cnt <= w_acc_cnt_nxt;
      r_dropped <= w_drop;
      if (w_acc_move) begin
        r_pend   <= r_acc;
        r_pend_v <= 1'b1;
      end else if (w_data_hs) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  // Count and sticky flags describe the current transfer; they reset when its descriptor is taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte_cnt <= 16'd0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_desc_hs) begin
      r_byte_cnt <= 16'd0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept && (r_byte_cnt != 16'hFFFF)) r_byte_cnt <= r_byte_cnt + 16'd1;
      if (w_drop && (r_state == ST_RECV)) r_ovf <= 1'b1;
`ifdef I3C_TTI_RX_ERR_FLAG_EN
      if (w_accept && byte_err_i) r_err <= 1'b1;
`endif
    end
  end

  assign rx_data_queue_wvalid_o = r_pend_v;
  assign rx_data_queue_wdata_o  = r_pend;
  assign rx_desc_queue_wvalid_o = (r_state == ST_DESC);
  assign rx_desc_queue_wdata_o  = {14'd0, w_err, r_ovf, r_byte_cnt};
  assign busy_o                 = (r_state != ST_IDLE);
  assign byte_dropped_o         = r_dropped;

endmodule

// File: tb/tb_tti_rx_packer.sv
// tb/tb_tti_rx_packer.sv - directed self-checking bench for tti_rx_packer
module tb_tti_rx_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        xfer_start = 1'b0;
  logic        xfer_end = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_d = 8'd0;
`ifdef I3C_TTI_RX_ERR_FLAG_EN
  logic        byte_err = 1'b0;
`endif
  logic        data_wvalid;
  logic        data_wready = 1'b1;
  logic [31:0] data_wdata;
  logic        desc_wvalid;
  logic        desc_wready = 1'b1;
  logic [31:0] desc_wdata;
  logic        busy;
  logic        dropped;

  int checks = 0;
  int failures = 0;
  int drops = 0;
  logic [31:0] dq[$];
  logic [31:0] descq[$];

  tti_rx_packer dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .xfer_start_i           (xfer_start),
    .xfer_end_i             (xfer_end),
    .byte_valid_i           (byte_valid),
    .byte_i                 (byte_d),
`ifdef I3C_TTI_RX_ERR_FLAG_EN
    .byte_err_i             (byte_err),
`endif
    .rx_data_queue_wvalid_o (data_wvalid),
    .rx_data_queue_wready_i (data_wready),
    .rx_data_queue_wdata_o  (data_wdata),
    .rx_desc_queue_wvalid_o (desc_wvalid),
    .rx_desc_queue_wready_i (desc_wready),
    .rx_desc_queue_wdata_o  (desc_wdata),
    .busy_o                 (busy),
    .byte_dropped_o         (dropped)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after posedge; the monitor samples on negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_wvalid && data_wready) dq.push_back(data_wdata);
      if (desc_wvalid && desc_wready) descq.push_back(desc_wdata);
      if (dropped) drops++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    xfer_start = 1'b1; tick(); xfer_start = 1'b0;
  endtask

  task automatic pulse_end();
    xfer_end = 1'b1; tick(); xfer_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1; byte_d = b; tick(); byte_valid = 1'b0;
  endtask

  task automatic wait_desc(input string tag, input int n);
    for (int i = 0; i < 60 && descq.size() < n; i++) tick();
    chk(tag, 32'(descq.size() >= n), 32'd1);
  endtask

  task automatic clear_scoreboard();
    dq.delete(); descq.delete(); drops = 0;
  endtask

  initial begin
    #3;
    chk("rst_data_wvalid", {31'd0, data_wvalid}, 32'd0);
    chk("rst_desc_wvalid", {31'd0, desc_wvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dropped", {31'd0, dropped}, 32'd0);
    chk("rst_data_wdata", data_wdata, 32'd0);
    chk("rst_desc_wdata", desc_wdata, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Five bytes: one full word, one padded residue, count 5
    clear_scoreboard();
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    pulse_end();
    wait_desc("t1_desc_seen", 1);
    tick(); tick();
    chk("t1_words", dq.size(), 32'd2);
    chk("t1_word0", dq[0], 32'h44332211);
    chk("t1_word1", dq[1], 32'h00000055);
    chk("t1_desc", descq[0], 32'h00000005);
    chk("t1_drops", drops, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Zero-length transfer
    clear_scoreboard();
    pulse_start();
    pulse_end();
    wait_desc("t2_desc_seen", 1);
    tick(); tick();
    chk("t2_words", dq.size(), 32'd0);
    chk("t2_desc_cnt", descq.size(), 32'd1);
    chk("t2_desc", descq[0], 32'h00000000);
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // Data queue full: 8 bytes held, 4 dropped, overflow flagged
    clear_scoreboard();
    data_wready = 1'b0;
    pulse_start();
    for (int i = 1; i <= 12; i++) send_byte(8'(i));
    pulse_end();
    tick(); tick(); tick();
    chk("t3_drops", drops, 32'd4);
    chk("t3_no_push", dq.size(), 32'd0);
    chk("t3_wvalid_held", {31'd0, data_wvalid}, 32'd1);
    chk("t3_wdata_held", data_wdata, 32'h04030201);
    chk("t3_busy_flush", {31'd0, busy}, 32'd1);
    chk("t3_no_desc_yet", {31'd0, desc_wvalid}, 32'd0);
    data_wready = 1'b1;
    wait_desc("t3_desc_seen", 1);
    tick(); tick();
    chk("t3_words", dq.size(), 32'd2);
    chk("t3_word0", dq[0], 32'h04030201);
    chk("t3_word1", dq[1], 32'h08070605);
    chk("t3_desc", descq[0], 32'h00010008);

    // Descriptor queue full: descriptor held, new start ignored
    clear_scoreboard();
    desc_wready = 1'b0;
    pulse_start();
    send_byte(8'hAA);
    pulse_end();
    for (int i = 0; i < 20 && !desc_wvalid; i++) tick();
    chk("t4_desc_wvalid", {31'd0, desc_wvalid}, 32'd1);
    chk("t4_desc_wdata", desc_wdata, 32'h00000001);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    pulse_start();
    tick(); tick(); tick();
    chk("t4_desc_wvalid_held", {31'd0, desc_wvalid}, 32'd1);
    chk("t4_desc_wdata_held", desc_wdata, 32'h00000001);
    desc_wready = 1'b1;
    wait_desc("t4_desc_seen", 1);
    tick(); tick();
    chk("t4_desc", descq[0], 32'h00000001);
    chk("t4_word0", dq[0], 32'h000000AA);
    chk("t4_start_ignored", {31'd0, busy}, 32'd0);

    // Reset in the middle of a transfer
    clear_scoreboard();
    pulse_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    chk("t5_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_data_wvalid", {31'd0, data_wvalid}, 32'd0);
    chk("t5_desc_wvalid", {31'd0, desc_wvalid}, 32'd0);
    chk("t5_desc_wdata", desc_wdata, 32'd0);
    tick();
    rst_n = 1'b1;
    pulse_end();
    for (int i = 0; i < 10; i++) tick();
    chk("t5_no_words", dq.size(), 32'd0);
    chk("t5_no_desc", descq.size(), 32'd0);
    chk("t5_idle", {31'd0, busy}, 32'd0);

`ifdef I3C_TTI_RX_ERR_FLAG_EN
    clear_scoreboard();
    pulse_start();
    send_byte(8'hAA);
    byte_err = 1'b1;
    send_byte(8'hBB);
    byte_err = 1'b0;
    pulse_end();
    wait_desc("t6_desc_seen", 1);
    tick();
    chk("t6_word0", dq[0], 32'h0000BBAA);
    chk("t6_desc", descq[0], 32'h00020002);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
